adc_spi_responder: RTL and testbench

//  Synthesizable responder for the DE0-Nano ADC128S022 SPI frame: the ADC side of the link.

---
 rtl/adc_spi_responder_pkg.sv | 22 ++
 rtl/adc_spi_responder_if.sv | 29 ++
 rtl/adc_spi_responder_sync.sv | 38 +++
 rtl/adc_spi_responder.sv | 169 ++++++++++++++++
 tb/tb_adc_spi_responder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/adc_spi_responder_pkg.sv
// Shared constants and types for the ADC128S022 SPI responder.
// Package: adc_spi_pkg
//   ADC_NCH, ADC_DW, ADC_FRAME_BITS, ADC_SYNC_STAGES : default geometry
//   adc_sample_t     : one ADC sample word
//   adc_resp_state_t : responder frame state
package adc_spi_pkg;

  localparam int ADC_NCH         = 8;
  localparam int ADC_DW          = 12;
  localparam int ADC_FRAME_BITS  = 16;
  localparam int ADC_SYNC_STAGES = 2;

  typedef logic [ADC_DW-1:0] adc_sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE,
    WAIT_IDLE
  } adc_resp_state_t;

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI link between an ADC master and the responder.
// Signals:
//   sclk : SPI clock, idles high (master -> responder)
//   cs_b : frame select, active low (master -> responder)
//   din  : channel address bits (master -> responder)
//   dout : serial sample, MSB first (responder -> master)
// Modports: master (drives sclk/cs_b/din), slave (drives dout).
interface adc_spi_responder_if;

  logic sclk;
  logic cs_b;
  logic din;
  logic dout;

  modport master (
    output sclk,
    output cs_b,
    output din,
    input  dout
  );

  modport slave (
    input  sclk,
    input  cs_b,
    input  din,
    output dout
  );

endinterface

// File: rtl/adc_spi_responder_sync.sv
// spi_edge_sync: multi-flop synchronizer for one asynchronous input, with
// single-cycle rise/fall pulses derived from the synced value and its
// previous value.
// Ports:
//   clk  : system clock
//   d    : asynchronous input
//   q    : synchronized level
//   rise : one-clk pulse on a synced 0->1 transition
//   fall : one-clk pulse on a synced 1->0 transition
// The synchronizer flops carry data only and are never reset: they keep
// tracking the pin through reset, so the level is valid as soon as reset
// is released.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   q_p1;

  always_ff @(posedge clk) begin
    sync_p0[0] <= d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_p0[i] <= sync_p0[i-1];
    end
    q_p1 <= sync_p0[SYNC_STAGES-1];
  end

  assign q    = sync_p0[SYNC_STAGES-1];
  assign rise =  q & ~q_p1;
  assign fall = ~q &  q_p1;

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: ADC side of the ADC128S022 SPI frame.
// Oversamples sclk/cs_b/din in the clk domain, captures the 3-bit channel
// address on sclk rises 3..5 and shifts out, MSB first behind leading zeros,
// the sample of the channel addressed in the previous frame.
// Ports:
//   clk        : system clock, at least 8x sclk
//   reset_b    : synchronous active-low reset
//   spi        : SPI link (slave modport: sclk, cs_b, din in; dout out)
//   ch_data    : flat sample bus, channel n = ch_data[n*DW +: DW]
//   frame_done : one-clk pulse after a complete frame commits its address
//   cur_ch     : channel whose sample goes out in the next frame
//   short_err  : sticky aborted-frame flag        (ADC_RESP_ERR_EN only)
//   frame_cnt  : wrapping completed-frame counter (ADC_RESP_ERR_EN only)
// Optional feature macro: ADC_RESP_ERR_EN adds short_err and frame_cnt.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int NCH         = ADC_NCH,
  parameter int DW          = ADC_DW,
  parameter int FRAME_BITS  = ADC_FRAME_BITS,
  parameter int SYNC_STAGES = ADC_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     reset_b,
  adc_spi_responder_if.slave       spi,
  input  logic [NCH*DW-1:0]        ch_data,
  output logic                     frame_done,
  output logic [$clog2(NCH)-1:0]   cur_ch
`ifdef ADC_RESP_ERR_EN
  ,
  output logic                     short_err,
  output logic [15:0]              frame_cnt
`endif
);

  localparam int AW = $clog2(NCH);
  localparam int CW = $clog2(FRAME_BITS + 1);

  // Address bits arrive on these 1-based sclk rises (ADD2, ADD1, ADD0).
  localparam int ADD2_RISE = 3;

  adc_resp_state_t        state;
  logic [FRAME_BITS-1:0]  shift;
  logic [CW-1:0]          rise_cnt;
  logic [2:0]             addr;
  logic                   done_pend;

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] din_sync_p0;
  logic                   din_s;
  logic [FRAME_BITS-1:0]  load_word;

  function automatic logic [AW-1:0] clamp_ch(input logic [2:0] a);
    if (int'(a) >= NCH) return AW'(NCH - 1);
    return AW'(a);
  endfunction

  // ---- input synchronizers ----
  // Only sclk edges matter; its synced level is deliberately left unused.
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .d    (spi.sclk),
    .q    (sclk_level_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (clk),
    .d    (spi.cs_b),
    .q    (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // din goes through the same depth as sclk so they stay aligned.
  always_ff @(posedge clk) begin
    din_sync_p0[0] <= spi.din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      din_sync_p0[i] <= din_sync_p0[i-1];
    end
  end
  assign din_s = din_sync_p0[SYNC_STAGES-1];

  assign load_word = {{(FRAME_BITS-DW){1'b0}}, ch_data[cur_ch*DW +: DW]};

  // dout is the MSB of the shift register; every non-shifting state keeps
  // the register cleared so dout idles low.
  assign spi.dout = shift[FRAME_BITS-1];

  // ---- frame state machine ----
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state      <= IDLE;
      shift      <= '0;
      rise_cnt   <= '0;
      addr       <= '0;
      cur_ch     <= '0;
      done_pend  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_pend;
      done_pend  <= 1'b0;
      unique case (state)
        IDLE: begin
          shift <= '0;
          if (cs_fall) begin
            // ch_data is sampled here only; later changes miss this frame.
            shift    <= load_word;
            rise_cnt <= '0;
            addr     <= '0;
            state    <= ACTIVE;
          end else if (!cs_s) begin
            // Came out of reset inside someone else's frame.
            state <= WAIT_IDLE;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            shift <= '0;
            state <= IDLE;
          end else if (sclk_rise) begin
            rise_cnt <= rise_cnt + 1'b1;
            if (rise_cnt == CW'(ADD2_RISE - 1)) addr[2] <= din_s;
            if (rise_cnt == CW'(ADD2_RISE))     addr[1] <= din_s;
            if (rise_cnt == CW'(ADD2_RISE + 1)) addr[0] <= din_s;
            if (rise_cnt == CW'(FRAME_BITS - 1)) begin
              cur_ch    <= clamp_ch(addr);
              done_pend <= 1'b1;
              shift     <= '0;
              state     <= DONE;
            end
          end else if (sclk_fall && rise_cnt != '0) begin
            // The fall before the first rise is the idle-high sclk
            // entering the frame, not a data fall.
            shift <= {shift[FRAME_BITS-2:0], 1'b0};
          end
        end
        DONE: begin
          shift <= '0;
          if (cs_rise) state <= IDLE;
        end
        WAIT_IDLE: begin
          shift <= '0;
          if (cs_s) state <= IDLE;
        end
        default: begin
          shift <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ADC_RESP_ERR_EN
  // ---- error / statistics ----
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      short_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (state == ACTIVE && cs_rise) short_err <= 1'b1;
      if (frame_done)                 frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: a table of SPI frames with
// hand-computed serial words, plus sequences for reset mid-frame and a
// mid-frame ch_data change.
module tb_adc_spi_responder;
  import adc_spi_pkg::*;

  localparam int HALF = 8;   // clk cycles per sclk half period

  logic               clk = 1'b0;
  logic               reset_b;
  logic [8*12-1:0]    ch_data;
  logic               frame_done;
  logic [2:0]         cur_ch;
`ifdef ADC_RESP_ERR_EN
  logic               short_err;
  logic [15:0]        frame_cnt;
`endif

  adc_spi_responder_if spi_if ();

  adc_spi_responder dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .spi        (spi_if),
    .ch_data    (ch_data),
    .frame_done (frame_done),
    .cur_ch     (cur_ch)
`ifdef ADC_RESP_ERR_EN
    ,
    .short_err  (short_err),
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int done_total = 0;
  always @(posedge clk) if (frame_done) done_total <= done_total + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    adc_sample_t val;    // sample placed on the channel selected by the previous frame
    logic [2:0]  addr;
    int          n;      // sclk periods
    int          ab;     // abort after this rise (0 = none)
    logic [15:0] word;   // bits sampled before each rise (up to 16)
    logic [2:0]  ch;     // expected cur_ch afterwards
    int          done;   // expected frame_done pulses
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input logic [2:0] a, input int nsclk, input int abort_at,
                           input int rst_at, input int chg_at, input int chg_ch,
                           input logic [11:0] chg_val,
                           output logic [15:0] word, output logic tail);
    word = '0;
    tail = 1'b0;
    spi_if.cs_b = 1'b0;
    wait_clks(HALF);
    for (int k = 1; k <= nsclk; k++) begin
      spi_if.sclk = 1'b0;
      spi_if.din  = (k == 3) ? a[2] : (k == 4) ? a[1] : (k == 5) ? a[0] : 1'b0;
      wait_clks(HALF);
      if (k <= 16) word = {word[14:0], spi_if.dout};
      else         tail = tail | spi_if.dout;
      spi_if.sclk = 1'b1;
      if (k == rst_at) reset_b = 1'b0;
      if (k == chg_at) ch_data[chg_ch*12 +: 12] = chg_val;
      wait_clks(HALF);
      if (k == rst_at) reset_b = 1'b1;
      if (k == abort_at) break;
    end
    wait_clks(HALF);
    spi_if.cs_b = 1'b1;
    spi_if.din  = 1'b0;
    wait_clks(2 * HALF);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic        t;
    int          d0;
    logic [2:0]  prev_ch;
    int          exp_fc;
    logic        exp_se;

    //            val     addr  n   ab  word     ch    done
    tbl[0] = '{12'hABC, 3'd3, 16, 0, 16'h0ABC, 3'd3, 1};
    tbl[1] = '{12'h5A5, 3'd0, 16, 0, 16'h05A5, 3'd0, 1};
    tbl[2] = '{12'hF00, 3'd5, 16, 7, 16'h0007, 3'd0, 0};
    tbl[3] = '{12'hABC, 3'd3, 20, 0, 16'h0ABC, 3'd3, 1};
    tbl[4] = '{12'hFFF, 3'd7, 16, 0, 16'h0FFF, 3'd7, 1};
    tbl[5] = '{12'h000, 3'd6, 16, 0, 16'h0000, 3'd6, 1};
    tbl[6] = '{12'h801, 3'd2, 16, 0, 16'h0801, 3'd2, 1};

    reset_b     = 1'b0;
    spi_if.sclk = 1'b1;
    spi_if.cs_b = 1'b1;
    spi_if.din  = 1'b0;
    ch_data     = '0;
    wait_clks(6);
    reset_b = 1'b1;
    wait_clks(4);

    check("reset_dout", {31'd0, spi_if.dout}, 32'd0);
    check("reset_cur_ch", {29'd0, cur_ch}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
`ifdef ADC_RESP_ERR_EN
    check("reset_short_err", {31'd0, short_err}, 32'd0);
    check("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif

    prev_ch = 3'd0;
    exp_fc  = 0;
    exp_se  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ch_data[prev_ch*12 +: 12] = tbl[i].val;
      d0 = done_total;
      run_frame(tbl[i].addr, tbl[i].n, tbl[i].ab, 0, 0, 0, 12'h000, w, t);
      check($sformatf("v%0d_word", i), {16'd0, w}, {16'd0, tbl[i].word});
      check($sformatf("v%0d_tail", i), {31'd0, t}, 32'd0);
      check($sformatf("v%0d_cur_ch", i), {29'd0, cur_ch}, {29'd0, tbl[i].ch});
      check($sformatf("v%0d_done", i), done_total - d0, tbl[i].done);
      check($sformatf("v%0d_dout_idle", i), {31'd0, spi_if.dout}, 32'd0);
      exp_fc += tbl[i].done;
      if (tbl[i].ab != 0) exp_se = 1'b1;
`ifdef ADC_RESP_ERR_EN
      check($sformatf("v%0d_frame_cnt", i), {16'd0, frame_cnt}, exp_fc);
      check($sformatf("v%0d_short_err", i), {31'd0, short_err}, {31'd0, exp_se});
`endif
      prev_ch = tbl[i].ch;
    end

    // Reset asserted at rise 9, released mid-frame: frame ignored.
    d0 = done_total;
    run_frame(3'd5, 16, 0, 9, 0, 0, 12'h000, w, t);
    check("rst_done", done_total - d0, 0);
    check("rst_cur_ch", {29'd0, cur_ch}, 32'd0);
    check("rst_dout", {31'd0, spi_if.dout}, 32'd0);
`ifdef ADC_RESP_ERR_EN
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_short_err", {31'd0, short_err}, 32'd0);
`endif

    // Following frame behaves like the first one.
    ch_data[0 +: 12] = 12'hABC;
    d0 = done_total;
    run_frame(3'd3, 16, 0, 0, 0, 0, 12'h000, w, t);
    check("post_rst_word", {16'd0, w}, 32'h0ABC);
    check("post_rst_cur_ch", {29'd0, cur_ch}, 32'd3);
    check("post_rst_done", done_total - d0, 1);
`ifdef ADC_RESP_ERR_EN
    check("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);
`endif

    // ch_data change at rise 2 must not reach the current frame.
    ch_data[3*12 +: 12] = 12'h3C3;
    d0 = done_total;
    run_frame(3'd1, 16, 0, 0, 2, 3, 12'hFFF, w, t);
    check("chg_word", {16'd0, w}, 32'h03C3);
    check("chg_cur_ch", {29'd0, cur_ch}, 32'd1);
    check("chg_done", done_total - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
